freq_meter: RTL and testbench
=============================

Name: freq_meter

Overview:
- Measures the frequency of an external signal or clock-like waveform (`sig_in`) against the 100 MHz system clock produced by `clk_gen_100M`.
- Synchronises `sig_in` into the `clk` domain and counts rising edges over a fixed gate window of `GATE_CYCLES` clock cycles.
- Reports the count with a one-cycle valid strobe.
- Used as the consumer/checker side of the clock path: the LED/seven-segment front end reads `count` for display and self-test.

Parameters:
- GATE_CYCLES, 100000000, gate window length in `clk` cycles (1 s at 100 MHz); minimum 2.
- CNT_W, 32, width of the edge counter and `count` output.

Ports:
- clk  in  1  system clock (100 MHz from `clk_gen_100M`)
- rst  in  1  reset, synchronous to `clk`, active-high
- sig_in  in  1  asynchronous signal under measurement
- start  in  1  single-cycle request to begin one measurement
- cont  in  1  continuous mode: re-arm automatically after each result
- busy  out  1  high while a measurement or result cycle is in progress
- valid  out  1  one-cycle strobe, `count`/`overflow` updated this cycle
- count  out  CNT_W  rising edges seen in the last gate window; held between results
- overflow  out  1  last result saturated; held between results

Behaviour:
- Reset (`rst` sampled high at a `clk` edge):
  - state = IDLE.
  - `busy`, `valid`, `overflow` = 0; `count` = 0.
  - Gate/edge counters = 0; synchroniser and edge-history flops = 0.
  - `rst` mid-measurement aborts it: no `valid`, previous result cleared.
- Input path:
  - 2-flop synchroniser s1→s2, then history flop s3.
  - `edge_pulse` = s2 & ~s3.
  - Latency: `sig_in` rising (setup-met) → `edge_pulse` high 2 cycles later, for exactly 1 cycle.
  - Synchroniser and history flops clock every cycle regardless of state.
  - If `sig_in` is high at reset release, one edge pulse occurs 2 cycles after reset; it is counted only if MEASURE is active then.
- State machine IDLE / MEASURE / DONE:
  - IDLE: `busy`=0. If `start` or `cont` is high → MEASURE; gate_cnt ← 0, edge_cnt ← 0.
  - MEASURE: `busy`=1.
    - gate_cnt increments every cycle.
    - edge_cnt increments on `edge_pulse`, saturating at 2^CNT_W−1; an increment attempted at saturation sets an internal ovf flag.
    - The cycle with gate_cnt == GATE_CYCLES−1 is the last counted cycle; its edge is included. Next state DONE.
    - Window is exactly GATE_CYCLES cycles.
  - DONE (1 cycle): `busy`=1.
    - `count` ← edge_cnt, `overflow` ← ovf, registered so they are visible together with `valid`=1 in the cycle after DONE is entered.
    - Edges in the DONE cycle are not counted (one dead cycle between back-to-back windows).
    - Next state: MEASURE if `cont`=1 (counters cleared), else IDLE.
- Timing: `start` sampled at edge T → MEASURE T+1..T+GATE_CYCLES → DONE at T+GATE_CYCLES+1 → `valid` high during cycle T+GATE_CYCLES+2.
- `start` while `busy`=1 is ignored; it is not queued.
- `cont` dropped during MEASURE: the current window completes and reports, then IDLE.
- `start` and `cont` high together are equivalent to `cont`.
- `count` and `overflow` change only on `valid` or `rst`.
- Counter widths:
  - gate_cnt is $clog2(GATE_CYCLES) bits.
  - edge_cnt is CNT_W bits, unsigned, saturating, never wraps.

Test Plan (GATE_CYCLES=100, CNT_W=32 unless noted; `sig_in` driven synchronous to `clk`):
1. Assert `rst` 3 cycles with `sig_in` toggling → `busy`=`valid`=`overflow`=0, `count`=0, no `valid` for 200 cycles with `start`/`cont` low.
2. `sig_in` period 10 cycles; `start` pulse at cycle T → `busy` high from T+1; `valid` exactly one cycle at T+102; `count`=10; `overflow`=0; `busy` low after.
3. `sig_in` held constant high for the whole run; `start` issued ≥3 cycles after reset → `count`=0.
4. `cont`=1, `sig_in` period 4 → successive `valid` strobes 101 cycles apart, each `count`=25; drop `cont` mid-window → one more result, then `busy`=0.
5. CNT_W=4, `sig_in` toggling every cycle (50 edges per window) → `count`=15, `overflow`=1. Next window with `sig_in` period 10 → `count`=10, `overflow`=0.
6. `start` then:
   - `start` again at T+40 → ignored, single result at T+102.
   - Separately, `rst` at T+50 → no `valid`, `count`=0, state IDLE.

Source files
------------

// File: rtl/freq_meter.sv
// Gated frequency meter: counts synchronised rising edges of sig_in over a fixed window of
// GATE_CYCLES clk cycles and reports the result with a one-cycle valid strobe.
module freq_meter #(
  parameter int unsigned GATE_CYCLES = 100000000,
  parameter int unsigned CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sig_in,
  input  logic             start,
  input  logic             cont,
  output logic             busy,
  output logic             valid,
  output logic [CNT_W-1:0] count,
  output logic             overflow
);

  localparam int unsigned GateW = $clog2(GATE_CYCLES);
  localparam logic [GateW-1:0] GateLast = GateW'(GATE_CYCLES - 1);

  typedef enum logic [1:0] {
    StIdle,
    StMeasure,
    StDone
  } state_e;

  state_e             state_q, state_d;
  logic [GateW-1:0]   gate_cnt_q, gate_cnt_d;
  logic [CNT_W-1:0]   edge_cnt_q, edge_cnt_d;
  logic               ovf_q, ovf_d;
  logic               valid_q, valid_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic               overflow_q, overflow_d;

  // s1/s2 form the synchroniser; s3 holds the previous synchronised level
  logic s1_q, s2_q, s3_q;
  logic edge_pulse;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
      s3_q <= 1'b0;
    end else begin
      s1_q <= sig_in;
      s2_q <= s1_q;
      s3_q <= s2_q;
    end
  end

  assign edge_pulse = s2_q & ~s3_q;

  always_comb begin
    state_d    = state_q;
    gate_cnt_d = gate_cnt_q;
    edge_cnt_d = edge_cnt_q;
    ovf_d      = ovf_q;
    valid_d    = 1'b0;
    count_d    = count_q;
    overflow_d = overflow_q;

    unique case (state_q)
      StIdle: begin
        if (start || cont) begin
          state_d    = StMeasure;
          gate_cnt_d = '0;
          edge_cnt_d = '0;
          ovf_d      = 1'b0;
        end
      end

      StMeasure: begin
        gate_cnt_d = gate_cnt_q + 1'b1;
        // Saturate rather than wrap; remember that an edge was lost
        if (edge_pulse) begin
          if (edge_cnt_q == '1) begin
            ovf_d = 1'b1;
          end else begin
            edge_cnt_d = edge_cnt_q + 1'b1;
          end
        end
        if (gate_cnt_q == GateLast) begin
          state_d = StDone;
        end
      end

      StDone: begin
        valid_d    = 1'b1;
        count_d    = edge_cnt_q;
        overflow_d = ovf_q;
        if (cont) begin
          state_d    = StMeasure;
          gate_cnt_d = '0;
          edge_cnt_d = '0;
          ovf_d      = 1'b0;
        end else begin
          state_d = StIdle;
        end
      end

      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      gate_cnt_q <= '0;
      edge_cnt_q <= '0;
      ovf_q      <= 1'b0;
      valid_q    <= 1'b0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      gate_cnt_q <= gate_cnt_d;
      edge_cnt_q <= edge_cnt_d;
      ovf_q      <= ovf_d;
      valid_q    <= valid_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

  assign busy     = (state_q != StIdle);
  assign valid    = valid_q;
  assign count    = count_q;
  assign overflow = overflow_q;

endmodule

// File: tb/tb_freq_meter.sv
// Bench for freq_meter: a 32-bit and a 4-bit instance share stimulus; a window-level model
// predicts every output each cycle, and directed sequences pin timing and counts to literals.
module tb_freq_meter;

  localparam int unsigned G = 100;

  logic        clk = 1'b0;
  logic        rst, sig_in, start, cont;
  logic        busy_b, valid_b, ovf_b, busy_s, valid_s, ovf_s;
  logic [31:0] count_b;
  logic [3:0]  count_s;

  int sig_per;
  bit sig_lvl;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  freq_meter #(.GATE_CYCLES(G), .CNT_W(32)) u_big (
    .clk     (clk),
    .rst     (rst),
    .sig_in  (sig_in),
    .start   (start),
    .cont    (cont),
    .busy    (busy_b),
    .valid   (valid_b),
    .count   (count_b),
    .overflow(ovf_b)
  );

  freq_meter #(.GATE_CYCLES(G), .CNT_W(4)) u_small (
    .clk     (clk),
    .rst     (rst),
    .sig_in  (sig_in),
    .start   (start),
    .cont    (cont),
    .busy    (busy_s),
    .valid   (valid_s),
    .count   (count_s),
    .overflow(ovf_s)
  );

  task automatic check(input string name, input longint act, input longint exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
  endtask

  // ---------------- model: window schedule + edge count from sampled history ----------------
  bit          hist [0:16383];
  int          k = 8;
  bit          ok = 0, act = 0;
  int          ws, we;
  bit          exp_busy, exp_valid, exp_ovf_b, exp_ovf_s;
  logic [31:0] exp_cnt_b;
  logic [3:0]  exp_cnt_s;

  function automatic bit hv(input int i);
    return (i < 0) ? 1'b0 : hist[i];
  endfunction

  // Rising edges of the sampled input whose pulse lands on edges a..b (2-cycle sync latency)
  function automatic int pulses(input int a, input int b);
    int n = 0;
    for (int j = a; j <= b; j++) if (hv(j - 2) && !hv(j - 3)) n++;
    return n;
  endfunction

  always @(negedge clk) begin
    int n;
    if (ok) begin
      check("big.busy", busy_b, exp_busy);
      check("big.valid", valid_b, exp_valid);
      check("big.count", count_b, exp_cnt_b);
      check("big.overflow", ovf_b, exp_ovf_b);
      check("small.busy", busy_s, exp_busy);
      check("small.valid", valid_s, exp_valid);
      check("small.count", count_s, exp_cnt_s);
      check("small.overflow", ovf_s, exp_ovf_s);
    end
    if (k < 16380) k++;
    hist[k] = sig_in;
    if (rst) begin
      hist[k] = 1'b0; hist[k-1] = 1'b0; hist[k-2] = 1'b0;
      ok = 1; act = 0;
      exp_busy = 0; exp_valid = 0; exp_cnt_b = '0; exp_cnt_s = '0;
      exp_ovf_b = 0; exp_ovf_s = 0;
    end else begin
      exp_valid = 0;
      if (act && k == we + 1) begin
        n         = pulses(ws + 1, we);
        exp_valid = 1;
        exp_cnt_b = 32'(n);
        exp_ovf_b = 0;
        exp_cnt_s = (n > 15) ? 4'd15 : 4'(n);
        exp_ovf_s = (n > 15);
        if (cont) begin ws = k; we = k + G; end
        else act = 0;
      end else if (!act && (start || cont)) begin
        act = 1; ws = k; we = k + G;
      end
      exp_busy = act;
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    int ph;
    ph = 0;
    sig_in = 1'b0;
    forever begin
      @(posedge clk); #1;
      if (sig_per == 0) sig_in = sig_lvl;
      else begin
        ph = (ph + 1) % sig_per;
        sig_in = (ph < sig_per / 2);
      end
    end
  end

  task automatic run_start(input int restart_at, input int rst_at, output int first,
                           output int nv, output bit busy1, output bit busy_after);
    start = 1; first = 0; nv = 0; busy1 = 0; busy_after = 1;
    for (int n = 1; n <= 160; n++) begin
      @(posedge clk); #1;
      start = (restart_at != 0 && n == restart_at);
      rst   = (rst_at != 0 && n >= rst_at && n < rst_at + 3);
      if (n == 1) busy1 = busy_b;
      if (valid_b) begin
        nv++;
        if (first == 0) first = n;
      end
      if (first != 0 && n == first + 1) busy_after = busy_b;
    end
  endtask

  task automatic wait_valid(output int n);
    n = 0;
    do begin
      @(posedge clk); #1;
      n++;
    end while (!valid_b && n < 300);
    if (!valid_b) check("valid_timeout", 0, 1);
  endtask

  initial begin
    int first, nv, n1, n2, n3;
    bit b1, ba;
    rst = 1; start = 0; cont = 0; sig_per = 2; sig_lvl = 0;

    // 1: reset with toggling input, then idle
    repeat (3) @(posedge clk);
    #1 rst = 0;
    check("rst.busy", busy_b, 0);
    check("rst.valid", valid_b, 0);
    check("rst.overflow", ovf_b, 0);
    check("rst.count", count_b, 0);
    nv = 0;
    repeat (200) begin @(posedge clk); #1; if (valid_b || valid_s) nv++; end
    check("idle.no_valid", nv, 0);

    // 2: period 10, single measurement
    sig_per = 10;
    repeat (5) @(posedge clk); #1;
    run_start(0, 0, first, nv, b1, ba);
    check("single.valid_at", first, 102);
    check("single.nvalid", nv, 1);
    check("single.busy_t1", b1, 1);
    check("single.busy_after", ba, 0);
    check("single.count", count_b, 10);
    check("single.overflow", ovf_b, 0);

    // 6a: second start while busy is ignored
    run_start(40, 0, first, nv, b1, ba);
    check("restart.valid_at", first, 102);
    check("restart.nvalid", nv, 1);
    check("restart.count", count_b, 10);

    // 6b: reset mid-measurement aborts and clears
    run_start(0, 50, first, nv, b1, ba);
    check("abort.nvalid", nv, 0);
    check("abort.count", count_b, 0);
    check("abort.busy", busy_b, 0);

    // 3: input held high across reset
    sig_per = 0; sig_lvl = 1;
    rst = 1;
    repeat (3) @(posedge clk);
    #1 rst = 0;
    repeat (3) @(posedge clk); #1;
    run_start(0, 0, first, nv, b1, ba);
    check("const.nvalid", nv, 1);
    check("const.count", count_b, 0);

    // 4: continuous mode, period 4
    sig_per = 4;
    repeat (5) @(posedge clk); #1;
    cont = 1;
    wait_valid(n1);
    check("cont.first_at", n1, 102);
    check("cont.count1", count_b, 25);
    wait_valid(n2);
    check("cont.gap", n2, 101);
    check("cont.count2", count_b, 25);
    repeat (50) @(posedge clk); #1;
    cont = 0;
    wait_valid(n3);
    check("cont.last_at", n3, 51);
    check("cont.count3", count_b, 25);
    @(posedge clk); #1;
    check("cont.busy_after", busy_b, 0);
    nv = 0;
    repeat (150) begin @(posedge clk); #1; if (valid_b) nv++; end
    check("cont.no_more", nv, 0);

    // 5: saturation on the 4-bit instance, then recovery
    sig_per = 2;
    repeat (5) @(posedge clk); #1;
    run_start(0, 0, first, nv, b1, ba);
    check("sat.big_count", count_b, 50);
    check("sat.small_count", count_s, 15);
    check("sat.small_ovf", ovf_s, 1);
    check("sat.big_ovf", ovf_b, 0);
    sig_per = 10;
    repeat (5) @(posedge clk); #1;
    run_start(0, 0, first, nv, b1, ba);
    check("recover.small_count", count_s, 10);
    check("recover.small_ovf", ovf_s, 0);
    check("recover.big_count", count_b, 10);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running at t=%0t, expected to finish", $time);
    $fatal(1);
  end

endmodule
